// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART receiver: parity modes,
// receive FSM state encoding and the 2-of-3 vote helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Oversampling tick counter with three-point capture around each bit centre;
// emits a one-clk bit_done strobe carrying the majority-voted bit value.
module uart_rx_bit_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick_i,
  input  logic                          rx_i,
  input  logic                          cnt_clr_i,
  input  logic                          cnt_en_i,
  input  logic                          vote_en_i,
  output logic [$clog2(OVERSAMPLE)-1:0] cnt_o,
  output logic                          bit_done_o,
  output logic                          bit_val_o
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_S0  = CW'(OVERSAMPLE - 3);
  localparam logic [CW-1:0] CNT_S1  = CW'(OVERSAMPLE - 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    smp_q, smp_d;
  logic          done_q, done_d;
  logic          val_q, val_d;

  // The counter value seen on a tick is the number of ticks already elapsed
  // since the last bit centre; the third sample is the line value at the tick
  // that lands on the next centre, so it is voted directly without storing it.
  always_comb begin
    cnt_d  = cnt_q;
    smp_d  = smp_q;
    done_d = 1'b0;
    val_d  = val_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (cnt_en_i && tick_i) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
      if (vote_en_i) begin
        if (cnt_q == CNT_S0) smp_d[0] = rx_i;
        if (cnt_q == CNT_S1) smp_d[1] = rx_i;
        if (cnt_q == CNT_MAX) begin
          done_d = 1'b1;
          val_d  = maj3(smp_q[0], smp_q[1], rx_i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      smp_q  <= 2'b11;
      done_q <= 1'b0;
      val_q  <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      smp_q  <= smp_d;
      done_q <= done_d;
      val_q  <= val_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign bit_done_o = done_q;
  assign bit_val_o  = val_q;

endmodule

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with optional parity and 1/2 stop bits, feeding a
// single-entry valid/ready output register with overrun reporting.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_rx_d,
  input  logic                 sampling,
  output logic [DATA_BITS-1:0] o_rx_d,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_rx_complete,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] START_MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic          PAR_EXP   = (PARITY == PAR_ODD);

  logic [1:0]           sync_q;
  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [BW-1:0]        bidx_q, bidx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] rx_d_q, rx_d_d;
  logic                 valid_q, valid_d;
  logic                 cmpl_q, cmpl_d;
  logic                 ferr_p_q, ferr_p_d;
  logic                 perr_p_q, perr_p_d;
  logic                 ovr_q, ovr_d;

  logic                 cnt_clr, cnt_en, vote_en;
  logic [CW-1:0]        cnt;
  logic                 bit_done, bit_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], i_rx_d};
  end
  assign rx_s = sync_q[1];

  uart_rx_bit_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_i    (sampling),
    .rx_i      (rx_s),
    .cnt_clr_i (cnt_clr),
    .cnt_en_i  (cnt_en),
    .vote_en_i (vote_en),
    .cnt_o     (cnt),
    .bit_done_o(bit_done),
    .bit_val_o (bit_val)
  );

  always_comb begin
    state_d  = state_q;
    bidx_d   = bidx_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    rx_d_d   = rx_d_q;
    valid_d  = valid_q;
    cmpl_d   = 1'b0;
    ferr_p_d = 1'b0;
    perr_p_d = 1'b0;
    ovr_d    = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    vote_en  = 1'b0;

    if (valid_q && i_rx_ready) valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (sampling && !rx_s) begin
          cnt_clr = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_en = 1'b1;
        if (sampling) begin
          if (rx_s) begin
            state_d = ST_IDLE;
          end else if (cnt == START_MID) begin
            cnt_clr = 1'b1;
            bidx_d  = '0;
            par_d   = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        cnt_en  = 1'b1;
        vote_en = 1'b1;
        if (bit_done) begin
          shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
          par_d   = par_q ^ bit_val;
          if (bidx_q == LAST_DATA) begin
            bidx_d  = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bidx_d = bidx_q + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        cnt_en  = 1'b1;
        vote_en = 1'b1;
        if (bit_done) begin
          perr_d  = ((par_q ^ bit_val) != PAR_EXP);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        cnt_en  = 1'b1;
        vote_en = 1'b1;
        if (bit_done) begin
          if (!bit_val) ferr_d = 1'b1;
          if (bidx_q == LAST_STOP) state_d = ST_DONE;
          else                     bidx_d  = bidx_q + BW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        // A same-cycle accept frees the buffer, so the new word replaces it.
        if (ferr_q) begin
          ferr_p_d = 1'b1;
        end else if (valid_q && !i_rx_ready) begin
          ovr_d = 1'b1;
        end else begin
          rx_d_d   = shreg_q;
          valid_d  = 1'b1;
          cmpl_d   = 1'b1;
          perr_p_d = perr_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bidx_q   <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      rx_d_q   <= '1;
      valid_q  <= 1'b0;
      cmpl_q   <= 1'b0;
      ferr_p_q <= 1'b0;
      perr_p_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bidx_q   <= bidx_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      rx_d_q   <= rx_d_d;
      valid_q  <= valid_d;
      cmpl_q   <= cmpl_d;
      ferr_p_q <= ferr_p_d;
      perr_p_q <= perr_p_d;
      ovr_q    <= ovr_d;
    end
  end

  assign o_rx_d        = rx_d_q;
  assign o_rx_valid    = valid_q;
  assign o_rx_complete = cmpl_q;
  assign o_frame_err   = ferr_p_q;
  assign o_parity_err  = perr_p_q;
  assign o_overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receivers (8N1, 8E1, 8N2) each on its own
// serial line, checked against a frame-level outcome model and fixed vectors.
module tb_uart_rx_param;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sampling;
  logic            i_rx_ready;
  logic [2:0]      rx_line;
  logic [2:0][7:0] rxd;
  logic [2:0]      vld, cmpl, ferr, perr, ovr;

  always #5 clk = ~clk;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .i_rx_d(rx_line[0]), .sampling(sampling),
    .o_rx_d(rxd[0]), .o_rx_valid(vld[0]), .i_rx_ready(i_rx_ready),
    .o_rx_complete(cmpl[0]), .o_frame_err(ferr[0]), .o_parity_err(perr[0]),
    .o_overrun(ovr[0]));

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) dut_e1 (
    .clk(clk), .rst_n(rst_n), .i_rx_d(rx_line[1]), .sampling(sampling),
    .o_rx_d(rxd[1]), .o_rx_valid(vld[1]), .i_rx_ready(i_rx_ready),
    .o_rx_complete(cmpl[1]), .o_frame_err(ferr[1]), .o_parity_err(perr[1]),
    .o_overrun(ovr[1]));

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(2)) dut_n2 (
    .clk(clk), .rst_n(rst_n), .i_rx_d(rx_line[2]), .sampling(sampling),
    .o_rx_d(rxd[2]), .o_rx_valid(vld[2]), .i_rx_ready(i_rx_ready),
    .o_rx_complete(cmpl[2]), .o_frame_err(ferr[2]), .o_parity_err(perr[2]),
    .o_overrun(ovr[2]));

  int n_cmpl[3] = '{0, 0, 0};
  int n_ferr[3] = '{0, 0, 0};
  int n_perr[3] = '{0, 0, 0};
  int n_ovr[3]  = '{0, 0, 0};
  int n_vcyc[3] = '{0, 0, 0};
  logic [7:0] last_word[3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (cmpl[k]) begin
        n_cmpl[k]++;
        last_word[k] = rxd[k];
      end
      if (ferr[k]) n_ferr[k]++;
      if (perr[k]) n_perr[k]++;
      if (ovr[k])  n_ovr[k]++;
      if (vld[k])  n_vcyc[k]++;
    end
  end

  int s_cmpl[3], s_ferr[3], s_perr[3], s_ovr[3], s_vcyc[3];
  int total = 0;
  int bad   = 0;

  task automatic snap();
    s_cmpl = n_cmpl;
    s_ferr = n_ferr;
    s_perr = n_perr;
    s_ovr  = n_ovr;
    s_vcyc = n_vcyc;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One oversampling slot: line settles through the synchronizer, then one tick.
  task automatic slot(input int cfg, input logic v);
    @(negedge clk);
    rx_line[cfg] = v;
    sampling = 1'b0;
    repeat (2) @(negedge clk);
    sampling = 1'b1;
    @(negedge clk);
    sampling = 1'b0;
  endtask

  task automatic send_frame(input int cfg, input logic [7:0] data, input logic pbit,
                            input logic s2, input int glitch_bit, input bit rdy_pulse,
                            input int cut_slot);
    logic q[$];
    int   npar;
    int   nstop;
    int   pulse_idx;
    npar  = (cfg == 1) ? 1 : 0;
    nstop = (cfg == 2) ? 2 : 1;
    repeat (4)  q.push_back(1'b1);
    repeat (16) q.push_back(1'b0);
    for (int b = 0; b < 8; b++)
      for (int s = 0; s < 16; s++)
        q.push_back((b == glitch_bit && s == 7) ? ~data[b] : data[b]);
    if (npar == 1) repeat (16) q.push_back(pbit);
    repeat (16) q.push_back(1'b1);
    if (nstop == 2) repeat (16) q.push_back(s2);
    repeat (4) q.push_back(1'b1);
    pulse_idx = 4 + 16 * (1 + 8 + npar + nstop - 1) + 8;
    for (int k = 0; k < q.size(); k++) begin
      if (k == cut_slot) break;
      slot(cfg, q[k]);
      if (rdy_pulse && k == pulse_idx) begin
        @(negedge clk);
        i_rx_ready = 1'b1;
        @(negedge clk);
        i_rx_ready = 1'b0;
      end
    end
  endtask

  typedef struct packed {
    logic deliver;
    logic perr;
    logic ferr;
  } pred_t;

  function automatic pred_t predict(input int cfg, input logic [7:0] d,
                                    input logic pbit, input logic s2);
    pred_t p;
    p.ferr    = (cfg == 2) && !s2;
    p.deliver = !p.ferr;
    p.perr    = (cfg == 1) && ((($countones(d) + int'(pbit)) % 2) != 0);
    return p;
  endfunction

  task automatic run_check(input string tag, input int cfg, input logic [7:0] d,
                           input logic pbit, input logic s2, input logic exp_cmpl,
                           input logic exp_perr, input logic exp_ferr);
    snap();
    send_frame(cfg, d, pbit, s2, -1, 1'b0, -1);
    check({tag, " complete"}, n_cmpl[cfg] - s_cmpl[cfg], 32'(exp_cmpl));
    check({tag, " parity_err"}, n_perr[cfg] - s_perr[cfg], 32'(exp_perr));
    check({tag, " frame_err"}, n_ferr[cfg] - s_ferr[cfg], 32'(exp_ferr));
    check({tag, " overrun"}, n_ovr[cfg] - s_ovr[cfg], 0);
    check({tag, " valid_cycles"}, n_vcyc[cfg] - s_vcyc[cfg], exp_cmpl ? 1 : 0);
    if (exp_cmpl) check({tag, " word"}, last_word[cfg], d);
  endtask

  typedef struct {
    int         cfg;
    logic [7:0] data;
    logic       pbit;
    logic       s2;
    logic       exp_cmpl;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t tbl[7];

  initial begin
    pred_t p;
    int    cfg;
    logic [7:0] d;
    logic  pb, s2;

    tbl[0] = '{0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{2, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{2, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_n      = 1'b0;
    sampling   = 1'b0;
    i_rx_ready = 1'b1;
    rx_line    = 3'b111;
    repeat (3) @(negedge clk);
    check("reset o_rx_d", rxd[0], 8'hFF);
    check("reset o_rx_valid", vld[0], 0);
    check("reset pulses", {cmpl[0], ferr[0], perr[0], ovr[0]}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_check($sformatf("vec%0d", i), tbl[i].cfg, tbl[i].data, tbl[i].pbit, tbl[i].s2,
                tbl[i].exp_cmpl, tbl[i].exp_perr, tbl[i].exp_ferr);

    // Short start pulse must be rejected, then a real frame still lands.
    snap();
    repeat (4)  slot(0, 1'b1);
    repeat (4)  slot(0, 1'b0);
    repeat (24) slot(0, 1'b1);
    check("start glitch complete", n_cmpl[0] - s_cmpl[0], 0);
    check("start glitch frame_err", n_ferr[0] - s_ferr[0], 0);
    check("start glitch valid", n_vcyc[0] - s_vcyc[0], 0);
    run_check("after glitch", 0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Overrun: consumer stalled, second frame dropped.
    i_rx_ready = 1'b0;
    snap();
    send_frame(0, 8'h11, 1'b0, 1'b1, -1, 1'b0, -1);
    check("ovr first complete", n_cmpl[0] - s_cmpl[0], 1);
    check("ovr first word", rxd[0], 8'h11);
    check("ovr first valid", vld[0], 1);
    snap();
    send_frame(0, 8'h22, 1'b0, 1'b1, -1, 1'b0, -1);
    check("ovr second overrun", n_ovr[0] - s_ovr[0], 1);
    check("ovr second complete", n_cmpl[0] - s_cmpl[0], 0);
    check("ovr second word kept", rxd[0], 8'h11);
    check("ovr second valid", vld[0], 1);
    snap();
    send_frame(0, 8'h22, 1'b0, 1'b1, -1, 1'b1, -1);
    check("accept overrun", n_ovr[0] - s_ovr[0], 0);
    check("accept complete", n_cmpl[0] - s_cmpl[0], 1);
    check("accept word", rxd[0], 8'h22);
    check("accept valid", vld[0], 1);
    i_rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("drain valid", vld[0], 0);

    run_check("pre-glitch", 0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    snap();
    send_frame(0, 8'hFF, 1'b0, 1'b1, 3, 1'b0, -1);
    check("data glitch complete", n_cmpl[0] - s_cmpl[0], 1);
    check("data glitch word", last_word[0], 8'hFF);

    // Reset in the middle of data bit 5 abandons the frame.
    snap();
    send_frame(0, 8'hB6, 1'b0, 1'b1, -1, 1'b0, 4 + 16 + 5 * 16 + 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async reset o_rx_d", rxd[0], 8'hFF);
    check("async reset valid", vld[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rx_line = 3'b111;
    repeat (40) slot(0, 1'b1);
    check("mid reset complete", n_cmpl[0] - s_cmpl[0], 0);
    check("mid reset errors", (n_ferr[0] - s_ferr[0]) + (n_perr[0] - s_perr[0]), 0);
    check("mid reset valid", n_vcyc[0] - s_vcyc[0], 0);
    run_check("post reset", 0, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 15; i++) begin
      cfg = $urandom_range(0, 2);
      d   = 8'($urandom);
      pb  = 1'($urandom);
      s2  = 1'($urandom);
      p   = predict(cfg, d, pb, s2);
      run_check($sformatf("rnd%0d", i), cfg, d, pb, s2, p.deliver, p.perr, p.ferr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

endmodule
